// File: rtl/bptt_history_if.sv
// rtl/bptt_history_if.sv - record capture/replay bus for the BPTT timestep history buffer
interface bptt_history_if #(
    parameter int WIDTH          = 32,
    parameter int NUM_LSTM       = 1,
    parameter int NUM_ITERATIONS = 8
);
    localparam int DW = NUM_LSTM * WIDTH;
    localparam int SW = (NUM_ITERATIONS > 1) ? $clog2(NUM_ITERATIONS) : 1;

    logic          i_start;
    logic          i_wr_en;
    logic          i_rd_en;
    logic [DW-1:0] i_a, i_i, i_f, i_o, i_c, i_h;
    logic [DW-1:0] o_a, o_i, o_f, o_o, o_c, o_h;
    logic [DW-1:0] o_c_prev;
    logic [SW-1:0] o_step;
    logic          o_valid;
    logic          o_full;
    logic          o_empty;

    modport master (
        output i_start, i_wr_en, i_rd_en,
        output i_a, i_i, i_f, i_o, i_c, i_h,
        input  o_a, o_i, o_f, o_o, o_c, o_h, o_c_prev, o_step,
        input  o_valid, o_full, o_empty
    );

    modport slave (
        input  i_start, i_wr_en, i_rd_en,
        input  i_a, i_i, i_f, i_o, i_c, i_h,
        output o_a, o_i, o_f, o_o, o_c, o_h, o_c_prev, o_step,
        output o_valid, o_full, o_empty
    );
endinterface

// File: rtl/bptt_history.sv
// rtl/bptt_history.sv - LSTM timestep history: fill forward, replay in reverse with c(t-1)
module bptt_history #(
    parameter int WIDTH          = 32,
    parameter int NUM_LSTM       = 1,
    parameter int NUM_ITERATIONS = 8
) (
    input logic           clk,
    input logic           rst,
    bptt_history_if.slave bus
);
    localparam int DW  = NUM_LSTM * WIDTH;
    localparam int REC = 6 * DW;
    localparam int CW  = $clog2(NUM_ITERATIONS + 1);
    localparam int SW  = (NUM_ITERATIONS > 1) ? $clog2(NUM_ITERATIONS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_ITERATIONS - 1);
    localparam logic [CW-1:0] FULL = CW'(NUM_ITERATIONS);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_wr, do_rd;
    logic [REC-1:0]  mem [NUM_ITERATIONS];
    logic [CW-1:0]   top_idx, prev_idx;
    logic [REC-1:0]  rd_rec, prev_rec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // i_start overrides both strobes; each state honours only its own strobe
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        if (bus.i_start) begin
            state_d = FILL;
            count_d = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (bus.i_wr_en) begin
                        do_wr   = 1'b1;
                        count_d = count_q + CW'(1);
                        if (count_q == LAST) state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.i_rd_en && count_q != '0) begin
                        do_rd   = 1'b1;
                        count_d = count_q - CW'(1);
                        if (count_q == CW'(1)) state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // Record layout {a,i,f,o,c,h}, h in the low word; storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[count_q[SW-1:0]] <= {bus.i_a, bus.i_i, bus.i_f, bus.i_o, bus.i_c, bus.i_h};
    end

    assign top_idx  = count_q - CW'(1);
    assign prev_idx = count_q - CW'(2);
    assign rd_rec   = mem[top_idx[SW-1:0]];
    assign prev_rec = mem[prev_idx[SW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.o_valid  <= 1'b0;
            bus.o_a      <= '0;
            bus.o_i      <= '0;
            bus.o_f      <= '0;
            bus.o_o      <= '0;
            bus.o_c      <= '0;
            bus.o_h      <= '0;
            bus.o_c_prev <= '0;
            bus.o_step   <= '0;
        end else begin
            bus.o_valid <= do_rd;
            if (do_rd) begin
                bus.o_a      <= rd_rec[6*DW-1 -: DW];
                bus.o_i      <= rd_rec[5*DW-1 -: DW];
                bus.o_f      <= rd_rec[4*DW-1 -: DW];
                bus.o_o      <= rd_rec[3*DW-1 -: DW];
                bus.o_c      <= rd_rec[2*DW-1 -: DW];
                bus.o_h      <= rd_rec[DW-1:0];
                // timestep 0 has no predecessor, so its c(t-1) is zero
                bus.o_c_prev <= (count_q == CW'(1)) ? '0 : prev_rec[2*DW-1 -: DW];
                bus.o_step   <= top_idx[SW-1:0];
            end
        end
    end

    assign bus.o_full  = (state_q == DRAIN) && (count_q == FULL);
    assign bus.o_empty = (count_q == '0);
endmodule

// File: tb/tb_bptt_history.sv
// tb/tb_bptt_history.sv - directed and randomized checks of bptt_history against a stack model
module tb_bptt_history;
    localparam int NI = 8;

    typedef struct packed {
        logic [31:0] a, i, f, o, c, h;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bptt_history_if #(.WIDTH(32), .NUM_LSTM(1), .NUM_ITERATIONS(NI)) bus ();

    bptt_history #(.WIDTH(32), .NUM_LSTM(1), .NUM_ITERATIONS(NI)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;

    rec_t        stk[$];
    bit          m_fill;
    logic        exp_valid;
    logic [2:0]  exp_step;
    logic [31:0] exp_a, exp_i, exp_f, exp_o, exp_c, exp_h, exp_cp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        m_fill    = 1'b1;
        exp_valid = 1'b0;
        exp_step  = '0;
        exp_a = '0; exp_i = '0; exp_f = '0; exp_o = '0; exp_c = '0; exp_h = '0; exp_cp = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(bus.o_valid), 64'(exp_valid));
        chk({tag, ".step"},  64'(bus.o_step),  64'(exp_step));
        chk({tag, ".a"},     64'(bus.o_a),     64'(exp_a));
        chk({tag, ".i"},     64'(bus.o_i),     64'(exp_i));
        chk({tag, ".f"},     64'(bus.o_f),     64'(exp_f));
        chk({tag, ".o"},     64'(bus.o_o),     64'(exp_o));
        chk({tag, ".c"},     64'(bus.o_c),     64'(exp_c));
        chk({tag, ".h"},     64'(bus.o_h),     64'(exp_h));
        chk({tag, ".cprev"}, 64'(bus.o_c_prev), 64'(exp_cp));
        chk({tag, ".full"},  64'(bus.o_full),  64'(!m_fill && stk.size() == NI));
        chk({tag, ".empty"}, 64'(bus.o_empty), 64'(stk.size() == 0));
    endtask

    // One clock: drive strobes, advance the model by the spec's rules, compare after the edge
    task automatic cycle(input string tag, input bit wr, input bit rd, input bit st, input rec_t r);
        rec_t t;
        bus.i_wr_en = wr;
        bus.i_rd_en = rd;
        bus.i_start = st;
        bus.i_a = r.a; bus.i_i = r.i; bus.i_f = r.f; bus.i_o = r.o; bus.i_c = r.c; bus.i_h = r.h;
        exp_valid = 1'b0;
        if (st) begin
            stk.delete();
            m_fill = 1'b1;
        end else if (m_fill) begin
            if (wr) begin
                stk.push_back(r);
                if (stk.size() == NI) m_fill = 1'b0;
            end
        end else if (rd && stk.size() > 0) begin
            t = stk.pop_back();
            exp_valid = 1'b1;
            exp_a = t.a; exp_i = t.i; exp_f = t.f; exp_o = t.o; exp_c = t.c; exp_h = t.h;
            exp_step = 3'(stk.size());
            exp_cp = (stk.size() > 0) ? stk[$].c : 32'd0;
            if (stk.size() == 0) m_fill = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    function automatic rec_t mk(input int t);
        rec_t r;
        r.a = 32'(t); r.i = 32'(t); r.f = 32'(t); r.o = 32'(t);
        r.c = 32'(100 + t); r.h = 32'(200 + t);
        return r;
    endfunction

    function automatic rec_t rnd();
        rec_t r;
        r.a = $urandom; r.i = $urandom; r.f = $urandom;
        r.o = $urandom; r.c = $urandom; r.h = $urandom;
        return r;
    endfunction

    initial begin
        rec_t junk;
        rec_t sr;
        bus.i_start = 1'b0; bus.i_wr_en = 1'b0; bus.i_rd_en = 1'b0;
        bus.i_a = '0; bus.i_i = '0; bus.i_f = '0; bus.i_o = '0; bus.i_c = '0; bus.i_h = '0;
        model_reset();

        // reset held with random inputs
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            junk = rnd();
            bus.i_wr_en = 1'($urandom); bus.i_rd_en = 1'($urandom); bus.i_start = 1'($urandom);
            bus.i_a = junk.a; bus.i_c = junk.c; bus.i_h = junk.h;
            @(posedge clk);
            #1;
        end
        chk("rst.valid", 64'(bus.o_valid), 64'd0);
        chk("rst.empty", 64'(bus.o_empty), 64'd1);
        chk("rst.full",  64'(bus.o_full),  64'd0);
        chk("rst.c",     64'(bus.o_c),     64'd0);
        chk("rst.cprev", 64'(bus.o_c_prev), 64'd0);
        chk("rst.step",  64'(bus.o_step),  64'd0);
        rst = 1'b1;
        junk = '0;
        cycle("idle", 1'b0, 1'b0, 1'b0, junk);

        // basic fill then full drain
        for (int t = 0; t < NI; t++) cycle("fill", 1'b1, 1'b0, 1'b0, mk(t));
        chk("full.after8", 64'(bus.o_full), 64'd1);
        junk = rnd();
        cycle("rd0wr", 1'b1, 1'b1, 1'b0, junk);
        chk("full.cleared", 64'(bus.o_full), 64'd0);
        chk("drain0.step", 64'(bus.o_step), 64'd7);
        chk("drain0.cprev", 64'(bus.o_c_prev), 64'd106);
        for (int k = 6; k >= 0; k--) begin
            cycle("drain", 1'b0, 1'b1, 1'b0, junk);
            chk("drain.valid", 64'(bus.o_valid), 64'd1);
            chk("drain.step", 64'(bus.o_step), 64'(k));
            chk("drain.c", 64'(bus.o_c), 64'(100 + k));
            chk("drain.h", 64'(bus.o_h), 64'(200 + k));
            chk("drain.cprev", 64'(bus.o_c_prev), (k > 0) ? 64'(99 + k) : 64'd0);
        end
        chk("drain.empty", 64'(bus.o_empty), 64'd1);
        cycle("post", 1'b0, 1'b1, 1'b0, junk);
        chk("post.valid", 64'(bus.o_valid), 64'd0);

        // read rejected in FILL, write rejected in DRAIN, start mid-drain with a read
        for (int t = 0; t < 3; t++) cycle("fill3", 1'b1, 1'b0, 1'b0, rnd());
        cycle("rdfill", 1'b0, 1'b1, 1'b0, rnd());
        chk("rdfill.valid", 64'(bus.o_valid), 64'd0);
        chk("rdfill.empty", 64'(bus.o_empty), 64'd0);
        for (int t = 3; t < NI; t++) cycle("fill5", 1'b1, 1'b0, 1'b0, rnd());
        cycle("wrdrain", 1'b1, 1'b0, 1'b0, rnd());
        for (int k = 0; k < 3; k++) cycle("rd3", 1'b0, 1'b1, 1'b0, rnd());
        cycle("start", 1'b0, 1'b1, 1'b1, rnd());
        chk("start.valid", 64'(bus.o_valid), 64'd0);
        chk("start.empty", 64'(bus.o_empty), 64'd1);
        chk("start.full",  64'(bus.o_full),  64'd0);

        // new sequence with signed extremes in the last timestep
        for (int t = 0; t < NI - 1; t++) cycle("seq2", 1'b1, 1'b0, 1'b0, mk(t + 10));
        sr = mk(17);
        sr.a = 32'hFFFF_FFFF;
        sr.h = 32'h8000_0000;
        cycle("seq2", 1'b1, 1'b0, 1'b0, sr);
        cycle("sgn", 1'b0, 1'b1, 1'b0, rnd());
        chk("sgn.a", 64'(bus.o_a), 64'h0000_0000_FFFF_FFFF);
        chk("sgn.h", 64'(bus.o_h), 64'h0000_0000_8000_0000);
        chk("sgn.cprev", 64'(bus.o_c_prev), 64'd116);
        for (int k = 0; k < NI; k++) cycle("seq2rd", 1'b0, 1'b1, 1'b0, rnd());

        // asynchronous reset mid-drain, between clock edges
        for (int t = 0; t < NI; t++) cycle("fill4", 1'b1, 1'b0, 1'b0, rnd());
        cycle("pre", 1'b0, 1'b1, 1'b0, rnd());
        cycle("pre", 1'b0, 1'b1, 1'b0, rnd());
        bus.i_rd_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst.valid", 64'(bus.o_valid), 64'd0);
        chk("arst.c",     64'(bus.o_c),     64'd0);
        chk("arst.h",     64'(bus.o_h),     64'd0);
        chk("arst.cprev", 64'(bus.o_c_prev), 64'd0);
        chk("arst.step",  64'(bus.o_step),  64'd0);
        chk("arst.empty", 64'(bus.o_empty), 64'd1);
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        cycle("arst.idle", 1'b0, 1'b1, 1'b0, rnd());

        // randomized traffic
        for (int n = 0; n < 1500; n++)
            cycle("rand", 1'($urandom), 1'($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 59) == 0), rnd());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bptt_history.md
# bptt_history

Timestep history buffer for LSTM backpropagation-through-time. During the forward pass it captures the cell's per-timestep activations (a, i, f, o, c, h) for NUM_ITERATIONS steps. During the backward pass it replays them in reverse timestep order, together with the previous-step cell state c(t-1), which the gradient stage needs. It sits between the lstm forward outputs and the backprop datapath that produces the weight/bias update buses.

## Interface
Parameters:
- WIDTH, 32, fixed-point word width (signed)
- NUM_LSTM, 1, number of LSTM cells; each activation port is NUM_LSTM*WIDTH bits
- NUM_ITERATIONS, 8, timesteps per sequence; buffer depth (>=2)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low
- i_start  input  1  synchronous clear; empties buffer, returns to FILL
- i_wr_en  input  1  write strobe; captures one timestep record
- i_a, i_i, i_f, i_o, i_c, i_h  input  NUM_LSTM*WIDTH each  forward activations of the current timestep
- i_rd_en  input  1  read strobe; pops the most recent stored timestep
- o_a, o_i, o_f, o_o, o_c, o_h  output  NUM_LSTM*WIDTH each  replayed record
- o_c_prev  output  NUM_LSTM*WIDTH  cell state of the timestep before the replayed one; 0 for timestep 0
- o_step  output  clog2(NUM_ITERATIONS)  timestep index of the replayed record
- o_valid  output  1  replay outputs valid this cycle
- o_full  output  1  NUM_ITERATIONS records stored (state DRAIN, nothing read yet)
- o_empty  output  1  no records stored

## Operation
- Storage: NUM_ITERATIONS entries, each {a,i,f,o,c,h} = 6*NUM_LSTM*WIDTH bits. Register array; contents not reset.
- Counter `count`, width clog2(NUM_ITERATIONS+1), holds the number of stored records.
- FILL state:
  - i_wr_en writes entry[count] and increments count.
  - i_rd_en ignored.
  - When a write brings count to NUM_ITERATIONS, the state goes to DRAIN.
- DRAIN state:
  - i_wr_en ignored.
  - i_rd_en with count>0 registers entry[count-1] onto o_a..o_h.
  - The same read registers entry[count-2].c onto o_c_prev, or 0 when count==1.
  - o_step <= count-1; count decrements.
  - A read that brings count to 0 returns the state to FILL.
- i_start has priority over wr/rd. It sets count=0, state=FILL, o_valid=0; output data holds.
- Simultaneous i_wr_en and i_rd_en: only the strobe legal in the current state acts.
- o_full = (state==DRAIN && count==NUM_ITERATIONS); o_empty = (count==0). Both combinational from registers.
- No arithmetic on data; values pass bit-exact (signed, no resizing).

## Timing
- Reset (rst=0, async): state=FILL, count=0, o_valid=0, o_a..o_h=0, o_c_prev=0, o_step=0, o_empty=1, o_full=0. Output registers clear immediately, not at the next edge.
- Write latency: a record written at edge N is readable from edge N+1.
- Read latency: 1 cycle. i_rd_en sampled at edge N gives o_valid=1 and data after edge N.
- o_valid is a one-cycle pulse per accepted read. Back-to-back reads give consecutive valid cycles, steps descending.
- Rejected read (FILL, or count==0): o_valid=0 next cycle; outputs hold.
- FILL->DRAIN: o_full asserts the cycle after the NUM_ITERATIONS-th write. It deasserts the cycle after the first read.
- Reset mid-DRAIN: remaining records are discarded (count=0). The next sequence overwrites from entry 0.

## Test plan
- Reset: hold rst=0 with random inputs -> all outputs 0, o_empty=1, o_full=0. Drive rst low mid-cycle -> outputs clear without waiting for a clock edge.
- Fill/drain, NUM_ITERATIONS=8, NUM_LSTM=1: write steps 0..7 with i_c=100+t, i_h=200+t, others=t. Then assert i_rd_en for 8 cycles:
  - o_step 7..0, o_c=107..100, o_h=207..200.
  - o_c_prev=106..100 then 0.
  - o_valid high for 8 cycles; o_empty=1 and state FILL afterwards.
- Illegal strobes:
  - i_rd_en during FILL (count=3) -> o_valid stays 0, count stays 3.
  - i_wr_en during DRAIN -> stored data unchanged, verified by subsequent reads.
- Full flag: 8th write -> o_full=1 next cycle. A write on the same cycle as the first read is ignored. o_full=0 after that read.
- i_start at count=5 during DRAIN, asserted together with i_rd_en -> count=0, FILL, o_valid=0. A new 8-step sequence then replays correctly.
- Signed passthrough: write i_h=32'h8000_0000 and i_a=-1 -> the same bit patterns read back unchanged.
